// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the main-memory bus arbiter.
// The slave modport is the arbiter's view; master is the bus environment.
interface mem_bus_arbiter_if #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 20,
  parameter int LINE_W = 128
);
  logic [NCH-1:0]        req_i;
  logic [NCH-1:0]        we_i;
  logic [NCH*ADDR_W-1:0] addr_i;
  logic [NCH*LINE_W-1:0] wdata_i;
  logic [NCH-1:0]        ready_o;
  logic [NCH-1:0]        err_o;
  logic [LINE_W-1:0]     rdata_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [LINE_W-1:0]     mem_wdata_o;
  logic                  mem_ready_i;
  logic [LINE_W-1:0]     mem_rdata_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    input  mem_ready_i, mem_rdata_i,
    output ready_o, err_o, rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    output mem_ready_i, mem_rdata_i,
    input  ready_o, err_o, rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter serialising line requests onto the main-memory bus,
// with a watchdog that turns a stalled access into an error response.
module mem_bus_arbiter #(
  parameter int NCH     = 2,
  parameter int ADDR_W  = 20,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst_n,
  mem_bus_arbiter_if.slave  bus
);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam logic [ADDR_W-1:0] ALIGN =
    ~(ADDR_W'((LINE_W / 8) - 1));
  localparam logic [NCH-1:0] ONE = NCH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [CH_W-1:0]   win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;

  logic              pick_vld;
  logic [CH_W-1:0]   pick;
  logic              busy;
  logic              resp;

  // Scan from the farthest offset down so the nearest requester after
  // last_q is the one left standing.
  always_comb begin
    pick_vld = 1'b0;
    pick     = last_q;
    for (int i = NCH; i >= 1; i--) begin
      if (bus.req_i[(int'(last_q) + i) % NCH]) begin
        pick_vld = 1'b1;
        pick     = CH_W'((int'(last_q) + i) % NCH);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          win_d   = pick;
          we_d    = bus.we_i[pick];
          addr_d  = bus.addr_i[pick*ADDR_W +: ADDR_W];
          wdata_d = bus.wdata_i[pick*LINE_W +: LINE_W];
          cnt_d   = '0;
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.mem_ready_i) begin
          rdata_d = we_q ? '0 : bus.mem_rdata_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        last_d  = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= CH_W'(NCH - 1);
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy = (state_q == S_BUSY);
  assign resp = (state_q == S_RESP);

  assign bus.mem_req_o   = busy;
  assign bus.mem_we_o    = busy & we_q;
  assign bus.mem_addr_o  = busy ? (addr_q & ALIGN) : '0;
  assign bus.mem_wdata_o = busy ? wdata_q : '0;

  assign bus.ready_o = resp ? (ONE << win_q) : '0;
  assign bus.err_o   = (resp && err_q) ? (ONE << win_q) : '0;
  assign bus.rdata_o = resp ? rdata_q : '0;
endmodule
